seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  operation request present.
REQ-005 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port alu_control  input  alu_control_t  operation select.
REQ-007 SHALL have ports src1, src2  input  WIDTH  operands.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-010 SHALL have port alu_result  output  WIDTH  registered result.
REQ-011 SHALL have ports zero, last_bit  output  1 each  (alu_result == 0), alu_result[0].
REQ-012 SHALL have port aligned_addr  output  aligned_addr_signal  word_aligned = result[1:0]==0, halfword_aligned = result[0]==0.

Function
REQ-013 SHALL use FSM states IDLE, CALC, DONE; req_ready = 1 only in IDLE.
REQ-014 SHALL accept a request when req_valid & req_ready; operands and opcode captured that edge.
REQ-015 SHALL treat ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA as single-cycle ops: IDLE->DONE, rsp_valid asserted the cycle after acceptance.
REQ-016 SHALL take the shift amount from src2[$clog2(WIDTH)-1:0]; SRA sign-fills; SLT signed, SLTU unsigned compare, result zero-extended to WIDTH.
REQ-017 SHALL treat MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU as iterative ops: IDLE->CALC, exactly WIDTH CALC cycles (one radix-2 step each), then DONE; rsp_valid asserted WIDTH+1 cycles after acceptance.
REQ-018 SHALL compute MUL as low WIDTH bits and MULH/MULHSU/MULHU as high WIDTH bits of the 2*WIDTH product with RISC-V signedness.
REQ-019 SHALL, on divisor zero, return quotient all-ones and remainder = src1 (both signed and unsigned) with unchanged latency.
REQ-020 SHALL, on signed overflow (src1 = -2^(WIDTH-1), src2 = -1), return DIV = src1 and REM = 0.
REQ-021 SHALL hold rsp_valid and all outputs stable in DONE until rsp_ready; DONE & rsp_ready -> IDLE.
REQ-022 SHALL ignore req_valid while in CALC or DONE (no queuing; request must be held by producer).
REQ-023 SHALL map unknown alu_control values to a single-cycle op with result 0.
REQ-024 SHALL derive zero, last_bit, aligned_addr combinationally from the registered alu_result.

Reset
REQ-025 SHALL on rst_n low immediately force state IDLE, rsp_valid 0, alu_result 0, iteration counter 0, including mid-CALC abort with no response.
REQ-026 SHALL, at reset, present zero = 1, last_bit = 0, aligned_addr word/halfword = 1, req_ready = 1 after release.

Configuration
REQ-027 SHALL, with HOLY_ALU_MULDIV_EN defined, implement REQ-017..REQ-020.
REQ-028 SHALL, without HOLY_ALU_MULDIV_EN, omit the mul/div datapath and complete M-ops as single-cycle ops with result 0; CALC state unreachable.

Structure
REQ-029 SHALL extend alu_control_t in holy_core_pkg with the eight M-op encodings; aligned_addr_signal stays in holy_core_pkg.
REQ-030 SHALL place FSM state enum and M-op decode helpers (is_muldiv) in holy_core_pkg.
REQ-031 SHALL implement the iterative datapath in one sub-module, seq_muldiv, with start/done handshake to the FSM.

Verification
REQ-032 SHALL check ADD 0x7FFFFFFF + 1 (WIDTH=32) -> rsp_valid next cycle, result 0x80000000, zero 0, word_aligned 1.
REQ-033 SHALL check MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 after 33 cycles; MULHU same operands -> 0xFFFFFFFE.
REQ-034 SHALL check DIV 7 / 0 -> 0xFFFFFFFF, REM 7 % 0 -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-035 SHALL check rsp_ready held low 5 cycles after SRA 0x80000000 >> 4 -> result 0xF8000000 stable, req_ready 0, new req_valid ignored.
REQ-036 SHALL check rst_n asserted at CALC cycle 10 of DIVU -> next cycle IDLE, rsp_valid 0, alu_result 0, no response after release.
REQ-037 SHALL rerun REQ-032 with WIDTH=16 and src2 = 0x0013 on SLL 1 -> result 0x0008 (shift amount 3).

Source files
------------

// File: rtl/holy_core_pkg.sv
// holy_core_pkg: ALU opcodes, flag bundle, FSM states and decode helpers.
// Build option HOLY_ALU_MULDIV_EN enables the iterative M-extension datapath.
package holy_core_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLTU   = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_control_t;

  typedef struct packed {
    logic word_aligned;
    logic halfword_aligned;
  } aligned_addr_signal;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } alu_state_t;

  function automatic logic is_muldiv(input alu_control_t op);
    return op inside {[ALU_MUL:ALU_REMU]};
  endfunction

  function automatic logic is_div_op(input alu_control_t op);
    return op inside {[ALU_DIV:ALU_REMU]};
  endfunction

  function automatic logic is_rem_op(input alu_control_t op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  function automatic logic src1_signed(input alu_control_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  function automatic logic src2_signed(input alu_control_t op);
    return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: radix-2 shift-add multiplier / restoring divider, WIDTH steps.
// Only built when HOLY_ALU_MULDIV_EN is defined.
`ifdef HOLY_ALU_MULDIV_EN
module seq_muldiv
  import holy_core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_control_t     op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   opnd, dvd, a_mag, b_mag;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH:0]     sum, shl, diff;
  logic [CW-1:0]      count;
  logic               busy, neg, div0, a_neg, b_neg;
  alu_control_t       op_q;

  always_comb begin
    a_neg = src1_signed(op) & src1[WIDTH-1];
    b_neg = src2_signed(op) & src2[WIDTH-1];
    a_mag = a_neg ? -src1 : src1;
    b_mag = b_neg ? -src2 : src2;
  end

  // acc = {product hi, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
         + (acc[0] ? {1'b0, opnd} : '0);
    shl  = acc[2*WIDTH-1:WIDTH-1];
    diff = shl - {1'b0, opnd};
    if (!is_div_op(op_q))
      acc_next = {sum, acc[WIDTH-1:1]};
    else if (diff[WIDTH])
      acc_next = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod   = neg ? -acc : acc;
    quo    = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    result = '0;
    unique case (op_q)
      ALU_MUL:                       result = prod[WIDTH-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[2*WIDTH-1:WIDTH];
      ALU_DIV, ALU_DIVU:             result = div0 ? '1 : quo;
      ALU_REM, ALU_REMU:             result = div0 ? dvd : rem;
      default:                       result = '0;
    endcase
  end

  assign done = busy && (count == CW'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      count <= '0;
      acc   <= '0;
      opnd  <= '0;
      dvd   <= '0;
      neg   <= 1'b0;
      div0  <= 1'b0;
      op_q  <= ALU_ADD;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
      op_q  <= op;
      dvd   <= src1;
      div0  <= is_div_op(op) && (src2 == '0);
      neg   <= a_neg ^ (b_neg & ~is_rem_op(op));
      opnd  <= is_div_op(op) ? b_mag : a_mag;
      acc   <= {{WIDTH{1'b0}}, is_div_op(op) ? a_mag : b_mag};
    end else if (busy) begin
      if (count == CW'(WIDTH)) begin
        busy <= 1'b0;
      end else begin
        acc   <= acc_next;
        count <= count + CW'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU, single-cycle base ops plus optional iterative M-ops.
// Build option HOLY_ALU_MULDIV_EN enables MUL/DIV; otherwise M-ops return 0.
module seq_alu
  import holy_core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  alu_control_t       alu_control,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   alu_result,
  output logic               zero,
  output logic               last_bit,
  output aligned_addr_signal aligned_addr
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state;
  logic [WIDTH-1:0] single_res, md_result;
  logic [SHW-1:0]   shamt;
  logic             accept, go_calc, md_done;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign shamt     = src2[SHW-1:0];

`ifdef HOLY_ALU_MULDIV_EN
  assign go_calc = accept & is_muldiv(alu_control);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (go_calc),
    .op     (alu_control),
    .src1   (src1),
    .src2   (src2),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign go_calc   = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  // M-ops and unknown opcodes fall through to 0 here
  always_comb begin
    single_res = '0;
    unique case (alu_control)
      ALU_ADD:  single_res = src1 + src2;
      ALU_SUB:  single_res = src1 - src2;
      ALU_AND:  single_res = src1 & src2;
      ALU_OR:   single_res = src1 | src2;
      ALU_XOR:  single_res = src1 ^ src2;
      ALU_SLT:  single_res = {{(WIDTH-1){1'b0}},
                              $signed(src1) < $signed(src2)};
      ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, src1 < src2};
      ALU_SLL:  single_res = src1 << shamt;
      ALU_SRL:  single_res = src1 >> shamt;
      ALU_SRA:  single_res = $signed(src1) >>> shamt;
      default:  single_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      alu_result <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          if (go_calc) begin
            state <= CALC;
          end else begin
            alu_result <= single_res;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        CALC: if (md_done) begin
          alu_result <= md_result;
          rsp_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zero     = (alu_result == '0);
  assign last_bit = alu_result[0];
  assign aligned_addr.word_aligned     = (alu_result[1:0] == 2'b00);
  assign aligned_addr.halfword_aligned = ~alu_result[0];

endmodule
